// File: rtl/tpc_mc_pkg.sv
// Shared types and encodings for the multi-cycle tpc core.
// Covers FSM states, RV32 opcode fields, halt causes and a GPR index check.
package tpc_mc_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_e;

    // HC_NONE doubles as the "retire normally" outcome computed in EXEC
    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_EBREAK   = 2'b01,
        HC_ILLEGAL  = 2'b10,
        HC_MISALIGN = 2'b11
    } halt_cause_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    function automatic logic idx_ok(input logic [4:0] idx, input int unsigned nr);
        return {27'b0, idx} < nr;
    endfunction

endpackage

// File: rtl/tpc_mc_if.sv
// Instruction fetch channel: valid/ready request, valid-only response.
interface tpc_mc_if #(
    parameter int unsigned XLEN = 32
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_resp_valid;
    logic [31:0]     ifu_resp_inst;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_inst
    );
endinterface

// File: rtl/tpc_mc_gpr.sv
// NR_GPR x XLEN register file: two operand reads, one debug read, one write.
// Entry 0 is never written, so every read of index 0 returns zero.
module tpc_mc_gpr #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NR_GPR = 16,
    localparam int unsigned IDX_W  = $clog2(NR_GPR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] ra1,
    input  logic [IDX_W-1:0] ra2,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2,
    output logic [XLEN-1:0]  dbg_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wa,
    input  logic [XLEN-1:0]  wd
);
    logic [NR_GPR-1:0][XLEN-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) regs_d[wa] = wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign rd1      = regs_q[ra1];
    assign rd2      = regs_q[ra2];
    assign dbg_data = regs_q[dbg_idx];

endmodule

// File: rtl/tpc_mc_core.sv
// Multi-cycle RV32 subset core sequenced FETCH -> WAIT -> EXEC -> WB,
// with halt reporting and an indexed debug read of the register file.
module tpc_mc_core
    import tpc_mc_pkg::*;
#(
    parameter  int unsigned     XLEN     = 32,
    parameter  int unsigned     NR_GPR   = 16,
    parameter  logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter  int unsigned     CNT_W    = 32,
    localparam int unsigned     IDX_W    = $clog2(NR_GPR)
) (
    input  logic             clk,
    input  logic             rst,
    tpc_mc_if.master         ifu,
    output logic [XLEN-1:0]  pc,
    input  logic [IDX_W-1:0] dbg_gpr_idx,
    output logic [XLEN-1:0]  dbg_gpr_data,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [XLEN-1:0]  halt_code
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] dnpc_q, dnpc_d;
    halt_cause_e     outc_q, outc_d;
    logic            wen_q, wen_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    halt_cause_e     halt_cause_q, halt_cause_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [IDX_W-1:0] ra1;

    halt_cause_e     ex_cause;
    logic [XLEN-1:0] ex_res, ex_dnpc;
    logic            ex_wen, ex_jump, use_rs1, use_rs2;
    logic            gpr_we;

    assign opcode = inst_q[6:0];
    assign rd_f   = inst_q[11:7];
    assign funct3 = inst_q[14:12];
    assign rs1_f  = inst_q[19:15];
    assign rs2_f  = inst_q[24:20];
    assign funct7 = inst_q[31:25];

    assign imm_i = XLEN'($signed(inst_q[31:20]));
    assign imm_u = XLEN'($signed({inst_q[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));

    // EBREAK borrows the rs1 port to capture x10 for halt_code
    assign ra1 = (inst_q == INST_EBREAK) ? IDX_W'(10) : rs1_f[IDX_W-1:0];

    tpc_mc_gpr #(.XLEN(XLEN), .NR_GPR(NR_GPR)) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ra1),
        .ra2      (rs2_f[IDX_W-1:0]),
        .dbg_idx  (dbg_gpr_idx),
        .rd1      (rs1_val),
        .rd2      (rs2_val),
        .dbg_data (dbg_gpr_data),
        .we       (gpr_we),
        .wa       (rd_f[IDX_W-1:0]),
        .wd       (res_q)
    );

    always_comb begin
        ex_cause = HC_ILLEGAL;
        ex_res   = '0;
        ex_dnpc  = pc_q + XLEN'(4);
        ex_wen   = 1'b0;
        ex_jump  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        if (inst_q == INST_EBREAK) begin
            ex_cause = HC_EBREAK;
            ex_res   = rs1_val;
        end else begin
            case (opcode)
                OP_IMM: if (funct3 == F3_ADD) begin
                    ex_cause = HC_NONE;
                    use_rs1  = 1'b1;
                    ex_wen   = 1'b1;
                    ex_res   = rs1_val + imm_i;
                end
                OP_REG: if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    ex_cause = HC_NONE;
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                    ex_wen   = 1'b1;
                    ex_res   = rs1_val + rs2_val;
                end
                OP_LUI: begin
                    ex_cause = HC_NONE;
                    ex_wen   = 1'b1;
                    ex_res   = imm_u;
                end
                OP_AUIPC: begin
                    ex_cause = HC_NONE;
                    ex_wen   = 1'b1;
                    ex_res   = pc_q + imm_u;
                end
                OP_JAL: begin
                    ex_cause = HC_NONE;
                    ex_wen   = 1'b1;
                    ex_jump  = 1'b1;
                    ex_res   = pc_q + XLEN'(4);
                    ex_dnpc  = pc_q + imm_j;
                end
                OP_JALR: if (funct3 == F3_ADD) begin
                    ex_cause = HC_NONE;
                    use_rs1  = 1'b1;
                    ex_wen   = 1'b1;
                    ex_jump  = 1'b1;
                    ex_res   = pc_q + XLEN'(4);
                    ex_dnpc  = rs1_val + imm_i;
                    ex_dnpc  = {ex_dnpc[XLEN-1:1], 1'b0};
                end
                default: ;
            endcase
            if (ex_cause == HC_NONE) begin
                if (!idx_ok(rd_f, NR_GPR) || (use_rs1 && !idx_ok(rs1_f, NR_GPR)) ||
                    (use_rs2 && !idx_ok(rs2_f, NR_GPR)))
                    ex_cause = HC_ILLEGAL;
                else if (ex_jump && ex_dnpc[1])
                    ex_cause = HC_MISALIGN;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        res_d        = res_q;
        dnpc_d       = dnpc_q;
        outc_d       = outc_q;
        wen_d        = wen_q;
        retired_d    = retired_q;
        halt_cause_d = halt_cause_q;
        halt_code_d  = halt_code_q;
        gpr_we       = 1'b0;
        case (state_q)
            FETCH: if (ifu.ifu_req_ready) state_d = WAIT;
            WAIT: if (ifu.ifu_resp_valid) begin
                inst_d  = ifu.ifu_resp_inst;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = ex_res;
                dnpc_d  = ex_dnpc;
                outc_d  = ex_cause;
                wen_d   = ex_wen;
                state_d = WB;
            end
            WB: begin
                case (outc_q)
                    HC_NONE: begin
                        gpr_we    = wen_q;
                        pc_d      = dnpc_q;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = FETCH;
                    end
                    HC_EBREAK: begin
                        retired_d    = retired_q + CNT_W'(1);
                        halt_cause_d = HC_EBREAK;
                        halt_code_d  = res_q;
                        state_d      = HALT;
                    end
                    default: begin
                        halt_cause_d = outc_q;
                        state_d      = HALT;
                    end
                endcase
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            res_q        <= '0;
            dnpc_q       <= '0;
            outc_q       <= HC_NONE;
            wen_q        <= 1'b0;
            retired_q    <= '0;
            halt_cause_q <= HC_NONE;
            halt_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            res_q        <= res_d;
            dnpc_q       <= dnpc_d;
            outc_q       <= outc_d;
            wen_q        <= wen_d;
            retired_q    <= retired_d;
            halt_cause_q <= halt_cause_d;
            halt_code_q  <= halt_code_d;
        end
    end

    assign ifu.ifu_req_valid = (state_q == FETCH) && !rst;
    assign ifu.ifu_req_addr  = pc_q;
    assign pc                = pc_q;
    assign retired           = retired_q;
    assign halted            = (state_q == HALT);
    assign halt_cause        = halt_cause_q;
    assign halt_code         = halt_code_q;

endmodule

// File: tb/tb_tpc_mc_core.sv
// Bench for tpc_mc_core: behavioural instruction memory with stall knobs plus
// fetch-address and register scoreboards drained once the core halts.
module tb_tpc_mc_core;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [3:0]  dbg_idx;
    logic [31:0] pc, dbg_data, retired, halt_code;
    logic        halted;
    logic [1:0]  halt_cause;

    tpc_mc_if #(.XLEN(32)) ifu ();

    tpc_mc_core dut (
        .clk          (clk),
        .rst          (rst),
        .ifu          (ifu),
        .pc           (pc),
        .dbg_gpr_idx  (dbg_idx),
        .dbg_gpr_data (dbg_data),
        .retired      (retired),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .halt_code    (halt_code)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // memory model state and test knobs
    logic [31:0] mem [0:63];
    int          stall_at = -1;
    int          ready_stall = 0;
    int          resp_delay = 0;
    bit          stale_en = 0;
    bit          m_busy, post_rst, addr_bad;
    int          st_cnt, rs_cnt, acc_cnt;
    logic [31:0] m_addr, hold_addr;
    logic [31:0] acc_addr [0:15];

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] add(int rd, int rs1, int rs2);
        return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] lui(int rd, int imm20);
        return {imm20[19:0], rd[4:0], 7'b0110111};
    endfunction
    function automatic logic [31:0] auipc(int rd, int imm20);
        return {imm20[19:0], rd[4:0], 7'b0010111};
    endfunction
    function automatic logic [31:0] jalr(int rd, int rs1, int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, rs1[4:0], 3'b000, rd[4:0], 7'b1100111};
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        logic [31:0] w;
        w = (a - RPC) >> 2;
        if (w < 64) return mem[w[5:0]];
        return 32'hFFFF_FFFF;
    endfunction

    // memory responder: decides its outputs just after each falling edge
    initial begin
        ifu.ifu_req_ready  = 0;
        ifu.ifu_resp_valid = 0;
        ifu.ifu_resp_inst  = '0;
        m_busy = 0; post_rst = 0; addr_bad = 0;
        st_cnt = 0; rs_cnt = 0; acc_cnt = 0;
        m_addr = '0; hold_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            ifu.ifu_req_ready  = 0;
            ifu.ifu_resp_valid = 0;
            if (rst) begin
                m_busy = 0; st_cnt = 0; rs_cnt = 0;
                post_rst = 1; acc_cnt = 0; addr_bad = 0;
            end else if (post_rst && stale_en) begin
                post_rst = 0;
                ifu.ifu_resp_valid = 1;
                ifu.ifu_resp_inst  = addi(1, 0, 99);
            end else begin
                post_rst = 0;
                if (m_busy) begin
                    if ((acc_cnt - 1) == stall_at && rs_cnt < resp_delay) rs_cnt++;
                    else begin
                        ifu.ifu_resp_valid = 1;
                        ifu.ifu_resp_inst  = mem_rd(m_addr);
                        m_busy = 0;
                        rs_cnt = 0;
                    end
                end else if (ifu.ifu_req_valid) begin
                    if (st_cnt == 0) hold_addr = ifu.ifu_req_addr;
                    else if (ifu.ifu_req_addr !== hold_addr) addr_bad = 1;
                    if (acc_cnt == stall_at && st_cnt < ready_stall) st_cnt++;
                    else begin
                        ifu.ifu_req_ready = 1;
                        m_addr = ifu.ifu_req_addr;
                        if (acc_cnt < 16) acc_addr[acc_cnt] = m_addr;
                        acc_cnt++;
                        m_busy = 1;
                        st_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic prep();
        rst = 1;
        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
        stall_at = -1; ready_stall = 0; resp_delay = 0; stale_en = 0;
        exp_q.delete();
        addr_q.delete();
        dbg_idx = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(output int cycles, output bit done);
        int start;
        rst = 0;
        start = cyc;
        done = 0;
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (halted) begin
                done = 1;
                cycles = cyc - start;
                break;
            end
        end
    endtask

    task automatic sb_drain(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (addr_q.size() > 0) begin
            logic [31:0] a;
            logic [31:0] got;
            a = addr_q.pop_front();
            got = (n < 16 && n < acc_cnt) ? acc_addr[n] : 32'hxxxx_xxxx;
            vectors++;
            if (got !== a) begin
                miscompares++;
                $display("FAIL %s fetch[%0d]: got %h want %h", tag, n, got, a);
            end
            n++;
        end
        vectors++;
        if (acc_cnt != n) begin
            miscompares++;
            $display("FAIL %s fetch_count: got %0d want %0d", tag, acc_cnt, n);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dbg_idx = e.idx;
            #1;
            vectors++;
            if (dbg_data !== e.val) begin
                miscompares++;
                $display("FAIL %s x%0d: got %h want %h", tag, e.idx, dbg_data, e.val);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        vectors++;
        if (ifu.ifu_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b want 0", ifu.ifu_req_valid);
        end
        vectors++;
        if (pc !== RPC || retired !== 0 || halted !== 0 || halt_cause !== 0 || halt_code !== 0) begin
            miscompares++;
            $display("FAIL reset_state: got pc=%h ret=%0d h=%b c=%b code=%h want pc=%h 0 0 0 0",
                     pc, retired, halted, halt_cause, halt_code, RPC);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_idx = 4'(i);
            #1;
            vectors++;
            if (dbg_data !== 32'h0) begin
                miscompares++; $display("FAIL reset_gpr x%0d: got %h want 0", i, dbg_data);
            end
        end
        rst = 0;
        #1;
        vectors++;
        if (ifu.ifu_req_valid !== 1'b1 || ifu.ifu_req_addr !== RPC) begin
            miscompares++;
            $display("FAIL reset_first_req: got v=%b a=%h want 1 %h", ifu.ifu_req_valid, ifu.ifu_req_addr, RPC);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic basic_prog(input string tag, input int exp_cycles);
        int cycles;
        bit done;
        mem[0] = addi(1, 0, 5);
        mem[1] = addi(2, 1, -7);
        mem[2] = add(3, 1, 2);
        mem[3] = 32'h0010_0073;
        for (int i = 0; i < 4; i++) addr_q.push_back(RPC + 32'(4 * i));
        exp_q.push_back('{4'd1, 32'h5});
        exp_q.push_back('{4'd2, 32'hFFFF_FFFE});
        exp_q.push_back('{4'd3, 32'h3});
        exp_q.push_back('{4'd0, 32'h0});
        run(cycles, done);
        vectors++;
        if (!done) begin
            miscompares++; $display("FAIL %s timeout: got no halt want halt", tag);
        end
        vectors++;
        if (cycles != exp_cycles) begin
            miscompares++; $display("FAIL %s cycles: got %0d want %0d", tag, cycles, exp_cycles);
        end
        vectors++;
        if (retired !== 4 || halt_cause !== 2'b01 || halt_code !== 0 || pc !== RPC + 12) begin
            miscompares++;
            $display("FAIL %s halt: got ret=%0d c=%b code=%h pc=%h want 4 01 0 %h",
                     tag, retired, halt_cause, halt_code, pc, RPC + 12);
        end
        sb_drain(tag);
        repeat (4) @(negedge clk);
        vectors++;
        if (halted !== 1 || ifu.ifu_req_valid !== 0 || retired !== 4 || pc !== RPC + 12) begin
            miscompares++;
            $display("FAIL %s frozen: got h=%b v=%b ret=%0d pc=%h want 1 0 4 %h",
                     tag, halted, ifu.ifu_req_valid, retired, pc, RPC + 12);
        end
    endtask

    task automatic test_basic();
        prep();
        basic_prog("basic", 16);
    endtask

    task automatic test_stall();
        prep();
        stall_at = 0; ready_stall = 3; resp_delay = 2;
        basic_prog("stall", 21);
        vectors++;
        if (addr_bad) begin
            miscompares++; $display("FAIL stall_addr_stable: got unstable want stable");
        end
    endtask

    task automatic test_lui_auipc();
        int cycles;
        bit done;
        prep();
        mem[0] = lui(10, 32'hABCDE);
        mem[1] = auipc(5, 1);
        mem[2] = 32'h0010_0073;
        for (int i = 0; i < 3; i++) addr_q.push_back(RPC + 32'(4 * i));
        exp_q.push_back('{4'd10, 32'hABCD_E000});
        exp_q.push_back('{4'd5, 32'h8000_1004});
        run(cycles, done);
        vectors++;
        if (!done || halt_code !== 32'hABCD_E000 || halt_cause !== 2'b01 || retired !== 3) begin
            miscompares++;
            $display("FAIL lui_halt: got done=%b code=%h c=%b ret=%0d want 1 abcde000 01 3",
                     done, halt_code, halt_cause, retired);
        end
        sb_drain("lui");
    endtask

    task automatic test_jalr_misalign();
        int cycles;
        bit done;
        prep();
        mem[0] = jalr(1, 0, 32'h103);
        addr_q.push_back(RPC);
        exp_q.push_back('{4'd1, 32'h0});
        run(cycles, done);
        vectors++;
        if (!done || halt_cause !== 2'b11 || retired !== 0 || pc !== RPC) begin
            miscompares++;
            $display("FAIL jalr_halt: got done=%b c=%b ret=%0d pc=%h want 1 11 0 %h",
                     done, halt_cause, retired, pc, RPC);
        end
        sb_drain("jalr");
    endtask

    task automatic test_illegal();
        int cycles;
        bit done;
        prep();
        mem[0] = addi(1, 0, 5);
        mem[1] = addi(17, 0, 1);
        addr_q.push_back(RPC);
        addr_q.push_back(RPC + 4);
        exp_q.push_back('{4'd1, 32'h5});
        run(cycles, done);
        vectors++;
        if (!done || halt_cause !== 2'b10 || retired !== 1 || pc !== RPC + 4 || halt_code !== 0) begin
            miscompares++;
            $display("FAIL illegal_rd: got done=%b c=%b ret=%0d pc=%h code=%h want 1 10 1 %h 0",
                     done, halt_cause, retired, pc, halt_code, RPC + 4);
        end
        sb_drain("illegal_rd");

        prep();
        mem[0] = 32'hFFFF_FFFF;
        addr_q.push_back(RPC);
        run(cycles, done);
        vectors++;
        if (!done || halt_cause !== 2'b10 || retired !== 0 || pc !== RPC) begin
            miscompares++;
            $display("FAIL illegal_ones: got done=%b c=%b ret=%0d pc=%h want 1 10 0 %h",
                     done, halt_cause, retired, pc, RPC);
        end
        sb_drain("illegal_ones");
    endtask

    task automatic test_reset_mid();
        int cycles;
        bit done;
        prep();
        mem[0] = addi(1, 0, 7);
        mem[1] = addi(0, 0, 9);
        mem[2] = 32'h0010_0073;
        stall_at = 0; resp_delay = 50;
        rst = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ifu.ifu_req_valid !== 0 || acc_cnt != 1) begin
            miscompares++;
            $display("FAIL midrst_wait: got v=%b acc=%0d want 0 1", ifu.ifu_req_valid, acc_cnt);
        end
        rst = 1;
        stall_at = -1; resp_delay = 0; stale_en = 1;
        @(negedge clk);
        vectors++;
        if (pc !== RPC || ifu.ifu_req_valid !== 0) begin
            miscompares++;
            $display("FAIL midrst_reset: got pc=%h v=%b want %h 0", pc, ifu.ifu_req_valid, RPC);
        end
        for (int i = 0; i < 3; i++) addr_q.push_back(RPC + 32'(4 * i));
        exp_q.push_back('{4'd1, 32'h7});
        exp_q.push_back('{4'd0, 32'h0});
        run(cycles, done);
        vectors++;
        if (!done || halt_cause !== 2'b01 || retired !== 3 || pc !== RPC + 8) begin
            miscompares++;
            $display("FAIL midrst_halt: got done=%b c=%b ret=%0d pc=%h want 1 01 3 %h",
                     done, halt_cause, retired, pc, RPC + 8);
        end
        vectors++;
        if (cycles != 13) begin
            miscompares++; $display("FAIL midrst_cycles: got %0d want 13", cycles);
        end
        sb_drain("midrst");
    endtask

    initial begin
        rst = 1;
        dbg_idx = 0;
        test_reset();
        test_basic();
        test_reset();
        test_stall();
        test_lui_auipc();
        test_jalr_misalign();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
